// File: rtl/q_agent_core.sv
// Q-learning agent for a GRID_W x GRID_H grid world: Q-table, step FSM and TD update.
// Optional: define Q_SATURATE_EN to clamp q_new instead of wrapping it.
module q_agent_core #(
    parameter int GRID_W      = 4,
    parameter int GRID_H      = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ALPHA_SHIFT = 1,
    parameter int GAMMA_SHIFT = 3,
    parameter int GOAL_ST     = 15,
    parameter logic signed [DATA_WIDTH-1:0] R_GOAL = 16'sh0100,
    parameter logic signed [DATA_WIDTH-1:0] R_STEP = -16'sh0010,
    parameter int MAX_STEPS   = 64,
    localparam int STATES     = GRID_W * GRID_H,
    localparam int ST_W       = $clog2(STATES),
    localparam int STEP_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ST_W-1:0]       i_first_st,
    input  logic                  i_at_valid,
    input  logic [1:0]            i_at,
    output logic                  o_at_ready,
    output logic [ST_W-1:0]       o_st,
    output logic                  o_valid_st,
    output logic [DATA_WIDTH-1:0] o_q_new,
    output logic                  o_valid,
    output logic                  o_episode_done,
    output logic                  o_timeout,
    output logic [STEP_W-1:0]     o_steps,
    input  logic [ST_W+1:0]       i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int ENTRIES = STATES * 4;
    localparam int EW      = DATA_WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACT  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_UPD  = 2'd3;

    logic [1:0]                   state;
    logic [ST_W-1:0]              st_q;
    logic [ST_W-1:0]              nxt_q;
    logic [1:0]                   at_q;
    logic [1:0]                   k_q;
    logic                         goal_q;
    logic signed [DATA_WIDTH-1:0] rew_q;
    logic signed [DATA_WIDTH-1:0] q_cur;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic [STEP_W-1:0]            steps_q;
    logic signed [DATA_WIDTH-1:0] q_tab [ENTRIES];

    logic [ST_W-1:0]              move_st;
    int                           row;
    int                           col;
    logic signed [DATA_WIDTH-1:0] scan_val;
    logic signed [EW-1:0]         mx_e;
    logic signed [EW-1:0]         gmax;
    logic signed [EW-1:0]         diff;
    logic signed [EW-1:0]         qn_e;
    logic [DATA_WIDTH-1:0]        q_new;
    logic                         term;

    function automatic int idx(input logic [ST_W-1:0] s, input logic [1:0] a);
        return int'(s) * 4 + int'(a);
    endfunction

    // Moves that would leave the grid keep the agent in place.
    always_comb begin
        row     = int'(st_q) / GRID_W;
        col     = int'(st_q) % GRID_W;
        move_st = st_q;
        unique case (i_at)
            2'd0: if (row > 0)          move_st = st_q - ST_W'(GRID_W);
            2'd1: if (row < GRID_H - 1) move_st = st_q + ST_W'(GRID_W);
            2'd2: if (col > 0)          move_st = st_q - ST_W'(1);
            2'd3: if (col < GRID_W - 1) move_st = st_q + ST_W'(1);
        endcase
    end

    always_comb begin
        scan_val = q_tab[idx(nxt_q, k_q)];
        mx_e     = goal_q ? '0 : EW'(max_q);
        gmax     = mx_e - (mx_e >>> GAMMA_SHIFT);
        diff     = EW'(rew_q) + gmax - EW'(q_cur);
        qn_e     = EW'(q_cur) + (diff >>> ALPHA_SHIFT);
`ifdef Q_SATURATE_EN
        // Top bits all equal means the result already fits in DATA_WIDTH.
        if (qn_e[EW-1:DATA_WIDTH-1] == '0 || qn_e[EW-1:DATA_WIDTH-1] == '1)
            q_new = qn_e[DATA_WIDTH-1:0];
        else
            q_new = {qn_e[EW-1], {(DATA_WIDTH-1){~qn_e[EW-1]}}};
`else
        q_new = qn_e[DATA_WIDTH-1:0];
`endif
        term = goal_q || (int'(steps_q) + 1 == MAX_STEPS);
    end

    assign o_at_ready = (state == S_ACT);
    assign o_st       = st_q;
    assign o_steps    = steps_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            st_q           <= '0;
            nxt_q          <= '0;
            at_q           <= '0;
            k_q            <= '0;
            goal_q         <= 1'b0;
            rew_q          <= '0;
            q_cur          <= '0;
            max_q          <= '0;
            steps_q        <= '0;
            o_valid_st     <= 1'b0;
            o_q_new        <= '0;
            o_valid        <= 1'b0;
            o_episode_done <= 1'b0;
            o_timeout      <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) q_tab[i] <= '0;
        end else begin
            o_valid_st     <= 1'b0;
            o_valid        <= 1'b0;
            o_episode_done <= 1'b0;
            o_timeout      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && int'(i_first_st) < STATES && int'(i_first_st) != GOAL_ST) begin
                        st_q       <= i_first_st;
                        steps_q    <= '0;
                        o_valid_st <= 1'b1;
                        state      <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (i_at_valid) begin
                        at_q   <= i_at;
                        nxt_q  <= move_st;
                        goal_q <= (int'(move_st) == GOAL_ST);
                        rew_q  <= (int'(move_st) == GOAL_ST) ? R_GOAL : R_STEP;
                        k_q    <= '0;
                        state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    q_cur <= q_tab[idx(st_q, at_q)];
                    if (k_q == 2'd0 || scan_val > max_q) max_q <= scan_val;
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) state <= S_UPD;
                end
                default: begin
                    q_tab[idx(st_q, at_q)] <= q_new;
                    o_q_new                <= q_new;
                    o_valid                <= 1'b1;
                    st_q                   <= nxt_q;
                    steps_q                <= steps_q + STEP_W'(1);
                    if (term) begin
                        o_episode_done <= 1'b1;
                        o_timeout      <= !goal_q;
                        state          <= S_IDLE;
                    end else begin
                        o_valid_st <= 1'b1;
                        state      <= S_ACT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         o_rd_data <= '0;
        else if (int'(i_rd_addr) < ENTRIES) o_rd_data <= q_tab[int'(i_rd_addr)];
        else                                o_rd_data <= '0;
    end

endmodule

// File: tb/tb_q_agent_core.sv
// Directed bench for q_agent_core: default instance, a MAX_STEPS=3 instance and an 8-bit instance.
module tb_q_agent_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start [3];
    logic [3:0] first [3];
    logic       atv   [3];
    logic [1:0] at    [3];
    logic [5:0] rda   [3];

    logic        ready [3];
    logic [3:0]  st    [3];
    logic        vst   [3];
    logic        val   [3];
    logic        done  [3];
    logic        tmo   [3];
    logic [15:0] qn    [3];
    logic [15:0] rdd   [3];
    logic [6:0]  steps [3];

    logic [1:0] steps_b;
    logic [7:0] qn_c;
    logic [7:0] rdd_c;
    assign steps[1] = {5'd0, steps_b};
    assign qn[2]    = {8'd0, qn_c};
    assign rdd[2]   = {8'd0, rdd_c};

    q_agent_core u_a (
        .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_first_st(first[0]),
        .i_at_valid(atv[0]), .i_at(at[0]), .o_at_ready(ready[0]), .o_st(st[0]),
        .o_valid_st(vst[0]), .o_q_new(qn[0]), .o_valid(val[0]), .o_episode_done(done[0]),
        .o_timeout(tmo[0]), .o_steps(steps[0]), .i_rd_addr(rda[0]), .o_rd_data(rdd[0])
    );

    q_agent_core #(.MAX_STEPS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_first_st(first[1]),
        .i_at_valid(atv[1]), .i_at(at[1]), .o_at_ready(ready[1]), .o_st(st[1]),
        .o_valid_st(vst[1]), .o_q_new(qn[1]), .o_valid(val[1]), .o_episode_done(done[1]),
        .o_timeout(tmo[1]), .o_steps(steps_b), .i_rd_addr(rda[1]), .o_rd_data(rdd[1])
    );

    q_agent_core #(.DATA_WIDTH(8), .R_GOAL(8'sh40), .R_STEP(8'sh7F)) u_c (
        .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_first_st(first[2]),
        .i_at_valid(atv[2]), .i_at(at[2]), .o_at_ready(ready[2]), .o_st(st[2]),
        .o_valid_st(vst[2]), .o_q_new(qn_c), .o_valid(val[2]), .o_episode_done(done[2]),
        .o_timeout(tmo[2]), .o_steps(steps[2]), .i_rd_addr(rda[2]), .o_rd_data(rdd_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_ep(input int i, input logic [3:0] s);
        start[i] = 1'b1;
        first[i] = s;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // Offers one action; returns at the negedge where o_valid is seen (T+6 when on time).
    // With inject, i_at_valid and i_start (start state 3) are also held during the first SCAN cycle.
    task automatic do_step(input int i, input logic [1:0] a, input bit inject);
        int n;
        n = 0;
        at[i]  = a;
        atv[i] = 1'b1;
        while (!ready[i] && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        if (inject) begin
            start[i] = 1'b1;
            first[i] = 4'd3;
        end else begin
            atv[i] = 1'b0;
        end
        n = 1;
        while (!val[i] && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                atv[i]   = 1'b0;
                start[i] = 1'b0;
            end
        end
        check_eq("step_latency", n, 6);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; first[i] = '0; atv[i] = 1'b0; at[i] = '0; rda[i] = '0;
        end

        // Reset state
        @(negedge clk);
        check_eq("rst_ready", ready[0], 0);
        check_eq("rst_st", st[0], 0);
        check_eq("rst_steps", steps[0], 0);
        check_eq("rst_outs", {vst[0], val[0], done[0], tmo[0]}, 0);
        check_eq("rst_qnew", qn[0], 0);
        check_eq("rst_rd", rdd[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: st14 right -> goal
        start_ep(0, 4'd14);
        check_eq("t1_vst", vst[0], 1);
        check_eq("t1_st", st[0], 14);
        check_eq("t1_ready", ready[0], 1);
        do_step(0, 2'd3, 1'b0);
        check_eq("t1_qnew", qn[0], 16'h0080);
        check_eq("t1_done", done[0], 1);
        check_eq("t1_timeout", tmo[0], 0);
        check_eq("t1_steps", steps[0], 1);
        check_eq("t1_no_vst", vst[0], 0);
        @(negedge clk);
        check_eq("t1_idle_ready", ready[0], 0);
        check_eq("t1_done_pulse", done[0], 0);

        // 2: st0 up -> wall clamp
        start_ep(0, 4'd0);
        do_step(0, 2'd0, 1'b0);
        check_eq("t2_qnew", qn[0], 16'hFFF8);
        check_eq("t2_vst", vst[0], 1);
        check_eq("t2_st", st[0], 0);
        check_eq("t2_ready", ready[0], 1);
        check_eq("t2_done", done[0], 0);

        // 5: stray start/valid during SCAN, then readback
        do_step(0, 2'd2, 1'b1);
        check_eq("t5_st", st[0], 0);
        check_eq("t5_qnew", qn[0], 16'hFFF8);
        check_eq("t5_steps", steps[0], 2);
        @(negedge clk);
        check_eq("t5_ready", ready[0], 1);
        check_eq("t5_no_extra_step", val[0], 0);
        rda[0] = {4'd0, 2'd2};
        @(negedge clk);
        check_eq("t5_rd_0_2", rdd[0], 16'hFFF8);
        rda[0] = {4'd14, 2'd3};
        @(negedge clk);
        check_eq("t5_rd_14_3", rdd[0], 16'h0080);

        // 3: step limit on MAX_STEPS=3 instance
        start_ep(1, 4'd0);
        do_step(1, 2'd3, 1'b0);
        check_eq("t3_q1", qn[1], 16'hFFF8);
        check_eq("t3_vst1", vst[1], 1);
        check_eq("t3_st1", st[1], 1);
        check_eq("t3_done1", done[1], 0);
        do_step(1, 2'd1, 1'b0);
        check_eq("t3_st2", st[1], 5);
        check_eq("t3_done2", done[1], 0);
        do_step(1, 2'd2, 1'b0);
        check_eq("t3_q3", qn[1], 16'hFFF8);
        check_eq("t3_done3", done[1], 1);
        check_eq("t3_timeout", tmo[1], 1);
        check_eq("t3_steps", steps[1], 3);
        check_eq("t3_no_vst", vst[1], 0);
        check_eq("t3_st3", st[1], 4);
        @(negedge clk);

        // 5: start at GOAL_ST is ignored
        start_ep(1, 4'd15);
        check_eq("t5_goal_vst", vst[1], 0);
        check_eq("t5_goal_ready", ready[1], 0);
        check_eq("t5_goal_st", st[1], 4);

        // 4: 8-bit instance, large step reward
        start_ep(2, 4'd0);
        do_step(2, 2'd2, 1'b0);
        check_eq("t4_q1", qn[2], 16'h003F);
        do_step(2, 2'd2, 1'b0);
        check_eq("t4_q2", qn[2], 16'h007B);
        do_step(2, 2'd2, 1'b0);
`ifdef Q_SATURATE_EN
        check_eq("t4_q3_sat", qn[2], 16'h007F);
`else
        check_eq("t4_q3_wrap", qn[2], 16'h00B3);
`endif

        // 6: async reset in the middle of a step
        do_step(0, 2'd3, 1'b0);
        check_eq("t6_pre_st", st[0], 1);
        check_eq("t6_pre_steps", steps[0], 3);
        check_eq("t6_pre_rd", rdd[0], 16'h0080);
        at[0]  = 2'd1;
        atv[0] = 1'b1;
        @(negedge clk);
        atv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t6_ready", ready[0], 0);
        check_eq("t6_st", st[0], 0);
        check_eq("t6_steps", steps[0], 0);
        check_eq("t6_rd", rdd[0], 0);
        check_eq("t6_outs", {vst[0], val[0], done[0], tmo[0]}, 0);
        check_eq("t6_qnew", qn[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            rda[0] = 6'(a);
            @(negedge clk);
            check_eq("t6_rd_clear", rdd[0], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
